async_fifo: RTL and testbench
=============================

// Module: async_fifo
// PURPOSE
//  Data FIFO of 2**ArraySize entries with DepthSize-bit words, clocked by one clock.
//  It keeps the dual-domain async-FIFO architecture: binary/Gray pointers and 2-flop
//  pointer synchronizers on both sides. The write and read sides can later be split
//  onto separate clocks without changing the flag logic. Sits between a producer and
//  a consumer as an elastic buffer.
// PARAMETERS
//  DepthSize  8  data word width in bits (wdata/rdata width, despite the name)
//  ArraySize  4  address bits; FIFO depth = 2**ArraySize = 16 entries
// PORTS
//  wclk    in   1          the one clock; all ports sampled/updated on its rising edge
//  wrst_n  in   1          reset, asynchronous, active-low
//  wreq    in   1          write request; accepted when wfull==0
//  wdata   in   DepthSize  write data, stored on accepted write
//  rreq    in   1          read request; pops when rempty==0
//  rdata   out  DepthSize  head-of-FIFO word (first-word fall-through)
//  wfull   out  1          FIFO full, registered
//  rempty  out  1          FIFO empty, registered
//  Interface rule: one clock; reset is asynchronous and active-low.
// BEHAVIOUR
//  - Reset (wrst_n=0, async): wptr/rptr binary and Gray = 0, all synchronizer flops = 0,
//    wfull=0, rempty=1. Memory array not reset; rdata is valid only while rempty==0.
//  - Pointers: ArraySize+1 bits (MSB = wrap bit); Gray = bin ^ (bin>>1).
//  - Write: wreq && !wfull at edge -> mem[wbin[A-1:0]] <= wdata, wbin++. Write while
//    full is ignored: no pointer move, no data change.
//  - Read: rdata = mem[rbin[A-1:0]], combinational (0 latency).
//    rreq && !rempty at edge -> rbin++. Read while empty is ignored.
//  - Sync: wptr Gray -> 2 flops -> rq2_wptr; rptr Gray -> 2 flops -> wq2_rptr.
//  - rempty <= (rgraynext == rq2_wptr).
//    wfull  <= (wgraynext == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]}).
//  - Latency: a write at edge k clears rempty at edge k+3. A read at edge k clears
//    wfull at edge k+3. Flags are pessimistic: they assert immediately, on the same
//    edge as the 16th write or the last read, and deassert late. They never report
//    false not-full or false not-empty.
//  - Simultaneous wreq and rreq: both act independently in the same cycle.
//  - Wrap-around: index wraps modulo 2**ArraySize. The MSB/Gray compare distinguishes
//    full from empty.
//  - Reset mid-operation: contents discarded; FIFO is empty on the first edge after release.
// STRUCTURE
//  - Shared package: default DepthSize/ArraySize and a pointer-width constant
//    PTR_W = ArraySize+1.
//  - One sub-module: sync_2ff #(WIDTH) (2-flop synchronizer, async active-low reset),
//    instantiated twice.
//  - Top module holds: memory array, write-pointer/full logic, read-pointer/empty logic.
// TESTING
//  1 Reset: wrst_n=0 for 2 edges -> wfull=0, rempty=1, no pointer movement.
//  2 Fill: write 1..16 on 16 consecutive edges -> wfull=1 at the 16th write edge.
//    A 17th write (99) is ignored.
//  3 Drain: rreq for 17 edges -> rdata shows 1,2,...,16 in order. rempty=1 after the
//    16th pop; the 17th pop is ignored and rdata holds.
//  4 Flag latency: single write into empty FIFO -> rempty falls exactly 3 edges later,
//    rdata = written value.
//  5 Wrap: 3 rounds of write-8/read-8 (values 0..23) -> data order preserved across the
//    index wrap; flags correct.
//  6 Concurrent + mid reset: simultaneous wreq/rreq at half full -> occupancy constant.
//    Assert wrst_n=0 mid-stream -> rempty=1 and wfull=0 immediately (async).

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Shared defaults for the async_fifo slice: word width, address width and the
// pointer width that carries the extra wrap bit.
package async_fifo_pkg;

  localparam int DEPTH_SIZE = 8;
  localparam int ARRAY_SIZE = 4;
  localparam int PTR_W      = ARRAY_SIZE + 1;

endpackage : async_fifo_pkg

// File: rtl/async_fifo_sync_2ff.sv
// Two-flop pointer synchronizer, cleared to zero by the asynchronous active-low reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule : sync_2ff

// File: rtl/async_fifo.sv
// Elastic FIFO with Gray-coded, cross-synchronized pointers; both sides run on wclk
// today, but the flag logic already assumes the pointers arrive through synchronizers.
module async_fifo
  import async_fifo_pkg::*;
#(
  parameter int DepthSize = DEPTH_SIZE,
  parameter int ArraySize = ARRAY_SIZE
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 wreq,
  input  logic [DepthSize-1:0] wdata,
  input  logic                 rreq,
  output logic [DepthSize-1:0] rdata,
  output logic                 wfull,
  output logic                 rempty
);

  localparam int PtrW    = ArraySize + 1;
  localparam int Entries = 2 ** ArraySize;

  function automatic logic [PtrW-1:0] bin2gray(input logic [PtrW-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  logic [DepthSize-1:0] mem [Entries];

  logic [PtrW-1:0] wbin_reg, wbin_next;
  logic [PtrW-1:0] wgray_reg, wgray_next;
  logic [PtrW-1:0] rbin_reg, rbin_next;
  logic [PtrW-1:0] rgray_reg, rgray_next;
  logic [PtrW-1:0] wq2_rptr, rq2_wptr;
  logic            wfull_reg, wfull_next;
  logic            rempty_reg, rempty_next;
  logic            winc, rinc;

  // ---------------- write side ----------------
  assign winc       = wreq && !wfull_reg;
  assign wbin_next  = wbin_reg + {{(PtrW-1){1'b0}}, winc};
  assign wgray_next = bin2gray(wbin_next);
  // Full when the next write pointer equals the read pointer with its top two Gray bits flipped.
  assign wfull_next = (wgray_next == {~wq2_rptr[ArraySize:ArraySize-1], wq2_rptr[ArraySize-2:0]});

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_reg  <= '0;
      wgray_reg <= '0;
      wfull_reg <= 1'b0;
    end else begin
      wbin_reg  <= wbin_next;
      wgray_reg <= wgray_next;
      wfull_reg <= wfull_next;
    end
  end

  // Storage is deliberately left out of reset; rdata is only meaningful while not empty.
  always_ff @(posedge wclk) begin
    if (winc) begin
      mem[wbin_reg[ArraySize-1:0]] <= wdata;
    end
  end

  // ---------------- read side ----------------
  assign rinc        = rreq && !rempty_reg;
  assign rbin_next   = rbin_reg + {{(PtrW-1){1'b0}}, rinc};
  assign rgray_next  = bin2gray(rbin_next);
  assign rempty_next = (rgray_next == rq2_wptr);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rbin_reg   <= '0;
      rgray_reg  <= '0;
      rempty_reg <= 1'b1;
    end else begin
      rbin_reg   <= rbin_next;
      rgray_reg  <= rgray_next;
      rempty_reg <= rempty_next;
    end
  end

  // First-word fall-through: the head entry is visible without a read cycle.
  assign rdata = mem[rbin_reg[ArraySize-1:0]];

  // ---------------- pointer crossings ----------------
  sync_2ff #(.WIDTH(PtrW)) u_sync_w2r (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (wgray_reg),
    .q     (rq2_wptr)
  );

  sync_2ff #(.WIDTH(PtrW)) u_sync_r2w (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (rgray_reg),
    .q     (wq2_rptr)
  );

  assign wfull  = wfull_reg;
  assign rempty = rempty_reg;

endmodule : async_fifo

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo: reset, fill/drain, flag latency, wrap and mid-stream reset.
module tb_async_fifo;

  logic       wclk;
  logic       wrst_n;
  logic       wreq;
  logic [7:0] wdata;
  logic       rreq;
  logic [7:0] rdata;
  logic       wfull;
  logic       rempty;

  int tests_run;
  int tests_failed;

  async_fifo #(.DepthSize(8), .ArraySize(4)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .wreq   (wreq),
    .wdata  (wdata),
    .rreq   (rreq),
    .rdata  (rdata),
    .wfull  (wfull),
    .rempty (rempty)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic test_reset();
    wrst_n = 1'b0;
    wreq   = 1'b1;
    rreq   = 1'b0;
    wdata  = 8'hEE;
    step();
    step();
    tests_run++;
    if (wfull !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_wfull: got %b expected 0", wfull);
    end
    tests_run++;
    if (rempty !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_rempty: got %b expected 1", rempty);
    end
    wreq   = 1'b0;
    wrst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    tests_run++;
    if (rempty !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_no_move: rempty got %b expected 1", rempty);
    end
    $display("[TB] reset: wfull=%b rempty=%b", wfull, rempty);
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      wreq  = 1'b1;
      wdata = 8'(i);
      step();
      tests_run++;
      if (wfull !== (i == 16)) begin
        tests_failed++;
        $display("FAIL fill_wfull[%0d]: got %b expected %b", i, wfull, (i == 16));
      end
      tests_run++;
      if (rempty !== (i <= 3)) begin
        tests_failed++;
        $display("FAIL fill_rempty[%0d]: got %b expected %b", i, rempty, (i <= 3));
      end
      $display("[TB] fill write %0d: wfull=%b rempty=%b", i, wfull, rempty);
    end
    wdata = 8'd99;
    step();
    wreq = 1'b0;
    tests_run++;
    if (wfull !== 1'b1) begin
      tests_failed++;
      $display("FAIL fill_overflow_wfull: got %b expected 1", wfull);
    end
    tests_run++;
    if (rdata !== 8'd1) begin
      tests_failed++;
      $display("FAIL fill_overflow_head: got %0d expected 1", rdata);
    end
    $display("[TB] fill write 17 (99) ignored: wfull=%b head=%0d", wfull, rdata);
  endtask

  task automatic test_drain();
    rreq = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tests_run++;
      if (rdata !== 8'(i)) begin
        tests_failed++;
        $display("FAIL drain_data[%0d]: got %0d expected %0d", i, rdata, i);
      end
      step();
      tests_run++;
      if (rempty !== (i == 16)) begin
        tests_failed++;
        $display("FAIL drain_rempty[%0d]: got %b expected %b", i, rempty, (i == 16));
      end
      tests_run++;
      if (wfull !== (i <= 3)) begin
        tests_failed++;
        $display("FAIL drain_wfull[%0d]: got %b expected %b", i, wfull, (i <= 3));
      end
      $display("[TB] drain pop %0d: rempty=%b wfull=%b", i, rempty, wfull);
    end
    step();
    rreq = 1'b0;
    tests_run++;
    if (rempty !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_underflow_rempty: got %b expected 1", rempty);
    end
    tests_run++;
    if (rdata !== 8'd1) begin
      tests_failed++;
      $display("FAIL drain_underflow_rdata: got %0d expected 1", rdata);
    end
    $display("[TB] drain pop 17 ignored: rempty=%b rdata=%0d", rempty, rdata);
  endtask

  task automatic test_latency();
    wreq  = 1'b1;
    wdata = 8'hA5;
    step();
    wreq = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (rempty !== (k < 3 - 1 ? 1'b1 : 1'b1)) begin
        tests_failed++;
        $display("FAIL latency_rempty[k+%0d]: got %b expected 1", k, rempty);
      end
      step();
    end
    tests_run++;
    if (rempty !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency_rempty[k+3]: got %b expected 0", rempty);
    end
    tests_run++;
    if (rdata !== 8'hA5) begin
      tests_failed++;
      $display("FAIL latency_rdata: got %h expected a5", rdata);
    end
    $display("[TB] latency: rempty fell at k+3, rdata=%h", rdata);
    rreq = 1'b1;
    step();
    rreq = 1'b0;
    tests_run++;
    if (rempty !== 1'b1) begin
      tests_failed++;
      $display("FAIL latency_pop_rempty: got %b expected 1", rempty);
    end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 8; j++) begin
        wreq  = 1'b1;
        wdata = 8'(r * 8 + j);
        step();
        tests_run++;
        if (wfull !== 1'b0) begin
          tests_failed++;
          $display("FAIL wrap_wfull[%0d]: got %b expected 0", r * 8 + j, wfull);
        end
      end
      wreq = 1'b0;
      for (int k = 0; k < 3; k++) step();
      rreq = 1'b1;
      for (int j = 0; j < 8; j++) begin
        tests_run++;
        if (rdata !== 8'(r * 8 + j)) begin
          tests_failed++;
          $display("FAIL wrap_data[%0d]: got %0d expected %0d", r * 8 + j, rdata, r * 8 + j);
        end
        step();
      end
      rreq = 1'b0;
      tests_run++;
      if (rempty !== 1'b1) begin
        tests_failed++;
        $display("FAIL wrap_rempty[round %0d]: got %b expected 1", r, rempty);
      end
      $display("[TB] wrap round %0d: values %0d..%0d, rempty=%b", r, r * 8, r * 8 + 7, rempty);
    end
  endtask

  task automatic test_concurrent_reset();
    for (int j = 0; j < 8; j++) begin
      wreq  = 1'b1;
      wdata = 8'h40 + 8'(j);
      step();
    end
    wreq = 1'b0;
    for (int k = 0; k < 3; k++) step();
    wreq = 1'b1;
    rreq = 1'b1;
    for (int j = 0; j < 8; j++) begin
      wdata = 8'h50 + 8'(j);
      tests_run++;
      if (rdata !== 8'h40 + 8'(j)) begin
        tests_failed++;
        $display("FAIL concur_data[%0d]: got %h expected %h", j, rdata, 8'h40 + 8'(j));
      end
      step();
      tests_run++;
      if (rempty !== 1'b0 || wfull !== 1'b0) begin
        tests_failed++;
        $display("FAIL concur_flags[%0d]: got rempty=%b wfull=%b expected 0 0", j, rempty, wfull);
      end
    end
    rreq = 1'b0;
    for (int j = 0; j < 8; j++) begin
      wdata = 8'h60 + 8'(j);
      step();
    end
    wreq = 1'b0;
    tests_run++;
    if (wfull !== 1'b1) begin
      tests_failed++;
      $display("FAIL concur_full: got %b expected 1", wfull);
    end
    $display("[TB] concurrent: occupancy held at 8, then filled, wfull=%b", wfull);
    @(posedge wclk);
    #3;
    wrst_n = 1'b0;
    #1;
    tests_run++;
    if (wfull !== 1'b0 || rempty !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_async: got wfull=%b rempty=%b expected 0 1", wfull, rempty);
    end
    $display("[TB] mid reset: wfull=%b rempty=%b before next edge", wfull, rempty);
    step();
    wrst_n = 1'b1;
    step();
    tests_run++;
    if (rempty !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_empty: got %b expected 1", rempty);
    end
    wreq  = 1'b1;
    wdata = 8'h3C;
    step();
    wreq = 1'b0;
    for (int k = 0; k < 3; k++) step();
    tests_run++;
    if (rempty !== 1'b0 || rdata !== 8'h3C) begin
      tests_failed++;
      $display("FAIL midreset_restart: got rempty=%b rdata=%h expected 0 3c", rempty, rdata);
    end
    $display("[TB] after reset: write 3c -> rempty=%b rdata=%h", rempty, rdata);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    wrst_n = 1'b1;
    wreq   = 1'b0;
    rreq   = 1'b0;
    wdata  = '0;
    #2;
    test_reset();
    test_fill();
    test_drain();
    test_latency();
    test_wrap();
    test_concurrent_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_async_fifo
